// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back stage and its forwarding consumers.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // memToReg encoding
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bundle: write-back inputs, decode read ports and commit trace outputs.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic [DATA_W-1:0] readData;
  logic [DATA_W-1:0] aluResult;
  logic [ADDR_W-1:0] muxRegFileData;
  logic              regWrite;
  logic              memToReg;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] wbData;
  logic [ADDR_W-1:0] lastWrAddr;
  logic [DATA_W-1:0] lastWrData;
  logic [CNT_W-1:0]  wrCount;

  modport master (
    output readData, aluResult, muxRegFileData, regWrite, memToReg, readReg1, readReg2,
    input  readData1, readData2, wbData, lastWrAddr, lastWrData, wrCount
  );

  modport slave (
    input  readData, aluResult, muxRegFileData, regWrite, memToReg, readReg1, readReg2,
    output readData1, readData2, wbData, lastWrAddr, lastWrData, wrCount
  );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// 2:1 write-back selector between memory read data and ALU result.
module wb_mux
  import wb_regfile_pkg::*;
(
  input  logic              sel,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] y
);

  assign y = (sel == WB_SEL_MEM) ? mem_data : alu_data;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the 32-entry register
// file and serves two bypassed combinational read ports to decode.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [ADDR_W-1:0] last_wr_addr;
  logic [DATA_W-1:0] last_wr_data;
  logic [CNT_W-1:0]  wr_count;
  logic              wr_en;
  logic              bypass_en;

  wb_mux u_wb_mux (
    .sel      (bus.memToReg),
    .mem_data (bus.readData),
    .alu_data (bus.aluResult),
    .y        (wb_data)
  );

  assign wr_en = bus.regWrite && (bus.muxRegFileData != REG_ZERO);
  // A write held off by reset must not leak through the bypass either.
  assign bypass_en = wr_en && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      last_wr_addr <= '0;
      last_wr_data <= '0;
      wr_count     <= '0;
    end else if (wr_en) begin
      regs[bus.muxRegFileData] <= wb_data;
      last_wr_addr             <= bus.muxRegFileData;
      last_wr_data             <= wb_data;
      wr_count                 <= wr_count + 1'b1;
    end
  end

  always_comb begin
    rd1 = regs[bus.readReg1];
    if (bypass_en && (bus.readReg1 == bus.muxRegFileData)) rd1 = wb_data;
    if (bus.readReg1 == REG_ZERO) rd1 = '0;
  end

  always_comb begin
    rd2 = regs[bus.readReg2];
    if (bypass_en && (bus.readReg2 == bus.muxRegFileData)) rd2 = wb_data;
    if (bus.readReg2 == REG_ZERO) rd2 = '0;
  end

  assign bus.readData1  = rd1;
  assign bus.readData2  = rd2;
  assign bus.wbData     = wb_data;
  assign bus.lastWrAddr = last_wr_addr;
  assign bus.lastWrData = last_wr_data;
  assign bus.wrCount    = wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomised scoreboard phase.
module tb_wb_regfile;

  logic clk;
  logic reset;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] got;

  logic [31:0] m_regs [32];
  logic [15:0] m_cnt;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  // reference model
  function automatic logic [31:0] m_wb();
    return bus.memToReg ? bus.readData : bus.aluResult;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (!reset && bus.regWrite && bus.muxRegFileData != 5'd0 && idx == bus.muxRegFileData)
      return m_wb();
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt  = 16'h0;
    m_addr = 5'h0;
    m_data = 32'h0;
  endtask

  // drivers
  task automatic drive_wb(input logic rw, input logic m2r, input logic [4:0] dest,
                          input logic [31:0] rd, input logic [31:0] alu);
    bus.regWrite       = rw;
    bus.memToReg       = m2r;
    bus.muxRegFileData = dest;
    bus.readData       = rd;
    bus.aluResult      = alu;
  endtask

  task automatic drive_rd(input logic [4:0] r1, input logic [4:0] r2);
    bus.readReg1 = r1;
    bus.readReg2 = r2;
  endtask

  task automatic drive_idle();
    drive_wb(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else if (bus.regWrite && bus.muxRegFileData != 5'd0) begin
      m_regs[bus.muxRegFileData] = m_wb();
      m_addr = bus.muxRegFileData;
      m_data = m_wb();
      m_cnt  = m_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive_wb(1'b1, 1'b0, 5'd1, 32'h0, 32'h0);
    drive_rd(5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive_wb(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom, $urandom);
      bus.muxRegFileData = 5'(i);
      drive_rd(5'(i), 5'(31 - i));
      exp_q.push_back(m_read(5'(i)));
      exp_q.push_back(m_read(5'(31 - i)));
      #1;
      got = bus.readData1; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset_rd1[%0d] got %h want %h", i, got, exp_v); end
      got = bus.readData2; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset_rd2[%0d] got %h want %h", i, got, exp_v); end
    end
    n_vec++;
    if (bus.wrCount !== 16'h0) begin n_err++; $display("FAIL reset_wrcount got %h want 0", bus.wrCount); end
    n_vec++;
    if (bus.lastWrAddr !== 5'h0) begin n_err++; $display("FAIL reset_lastaddr got %h want 0", bus.lastWrAddr); end
    n_vec++;
    if (bus.lastWrData !== 32'h0) begin n_err++; $display("FAIL reset_lastdata got %h want 0", bus.lastWrData); end
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 5'd5, $urandom, 32'h0000_1234);
    drive_rd(5'd5, 5'd0);
    tick();
    n_vec++;
    if (bus.lastWrAddr !== 5'd5) begin n_err++; $display("FAIL alu_lastaddr got %h want 05", bus.lastWrAddr); end
    n_vec++;
    if (bus.wrCount !== 16'd1) begin n_err++; $display("FAIL alu_wrcount got %h want 0001", bus.wrCount); end
    n_vec++;
    if (bus.lastWrData !== 32'h0000_1234) begin n_err++; $display("FAIL alu_lastdata got %h want 00001234", bus.lastWrData); end
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0000_1234) begin n_err++; $display("FAIL alu_rd1 got %h want 00001234", bus.readData1); end
  endtask

  task automatic test_mem_bypass();
    @(negedge clk);
    drive_wb(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0000_0001);
    drive_rd(5'd0, 5'd7);
    #1;
    n_vec++;
    if (bus.readData2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_bypass_rd2 got %h want deadbeef", bus.readData2); end
    n_vec++;
    if (bus.wbData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_wbdata got %h want deadbeef", bus.wbData); end
    tick();
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++;
    if (bus.readData2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_array_rd2 got %h want deadbeef", bus.readData2); end
    n_vec++;
    if (bus.wrCount !== 16'd2) begin n_err++; $display("FAIL mem_wrcount got %h want 0002", bus.wrCount); end
  endtask

  task automatic test_zero_write();
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    drive_rd(5'd0, 5'd0);
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0) begin n_err++; $display("FAIL zero_pre_rd1 got %h want 0", bus.readData1); end
    tick();
    n_vec++;
    if (bus.wrCount !== 16'd2) begin n_err++; $display("FAIL zero_wrcount got %h want 0002", bus.wrCount); end
    n_vec++;
    if (bus.lastWrAddr !== 5'd7) begin n_err++; $display("FAIL zero_lastaddr got %h want 07", bus.lastWrAddr); end
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0) begin n_err++; $display("FAIL zero_post_rd1 got %h want 0", bus.readData1); end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    drive_wb(1'b0, 1'bx, 5'd3, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    drive_rd(5'd3, 5'd3);
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0) begin n_err++; $display("FAIL nowr_pre_rd1 got %h want 0", bus.readData1); end
    tick();
    @(negedge clk);
    bus.memToReg = 1'b1;
    tick();
    @(negedge clk);
    bus.memToReg = 1'b0;
    tick();
    n_vec++;
    if (bus.readData2 !== 32'h0) begin n_err++; $display("FAIL nowr_rd2 got %h want 0", bus.readData2); end
    n_vec++;
    if (bus.lastWrData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL nowr_lastdata got %h want deadbeef", bus.lastWrData); end
    n_vec++;
    if (bus.wrCount !== 16'd2) begin n_err++; $display("FAIL nowr_wrcount got %h want 0002", bus.wrCount); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 5'd4, 32'h0, 32'h0000_0011);
    drive_rd(5'd4, 5'd4);
    tick();
    @(negedge clk);
    bus.aluResult = 32'h0000_0022;
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0000_0022) begin n_err++; $display("FAIL b2b_rd1_bypass got %h want 00000022", bus.readData1); end
    n_vec++;
    if (bus.readData2 !== 32'h0000_0022) begin n_err++; $display("FAIL b2b_rd2_bypass got %h want 00000022", bus.readData2); end
    tick();
    @(negedge clk);
    drive_wb(1'b1, 1'b1, 5'd4, 32'h0000_0033, 32'h0000_0044);
    tick();
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0000_0033) begin n_err++; $display("FAIL b2b_rd1 got %h want 00000033", bus.readData1); end
    n_vec++;
    if (bus.readData2 !== 32'h0000_0033) begin n_err++; $display("FAIL b2b_rd2 got %h want 00000033", bus.readData2); end
    n_vec++;
    if (bus.wrCount !== 16'd5) begin n_err++; $display("FAIL b2b_wrcount got %h want 0005", bus.wrCount); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 5'd9, 32'h0, 32'h0000_0055);
    drive_rd(5'd9, 5'd9);
    tick();
    @(negedge clk);
    bus.aluResult = 32'h0000_0066;
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (bus.readData1 !== 32'h0) begin n_err++; $display("FAIL rstmid_rd1 got %h want 0", bus.readData1); end
    n_vec++;
    if (bus.wrCount !== 16'h0) begin n_err++; $display("FAIL rstmid_wrcount got %h want 0", bus.wrCount); end
    n_vec++;
    if (bus.lastWrData !== 32'h0) begin n_err++; $display("FAIL rstmid_lastdata got %h want 0", bus.lastWrData); end
    tick();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    tick();
    n_vec++;
    if (bus.readData1 !== 32'h0) begin n_err++; $display("FAIL rstmid_post_rd1 got %h want 0", bus.readData1); end
    n_vec++;
    if (bus.wrCount !== 16'h0) begin n_err++; $display("FAIL rstmid_post_wrcount got %h want 0", bus.wrCount); end
  endtask

  task automatic test_random();
    logic [4:0] dest;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      dest = (c % 8 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      drive_wb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dest, $urandom, $urandom);
      drive_rd((c % 3 == 0) ? dest : 5'($urandom_range(0, 31)),
               (c % 5 == 0) ? dest : 5'($urandom_range(0, 31)));
      exp_q.push_back(m_read(bus.readReg1));
      exp_q.push_back(m_read(bus.readReg2));
      exp_q.push_back(m_wb());
      exp_q.push_back({16'h0, m_cnt});
      exp_q.push_back({27'h0, m_addr});
      exp_q.push_back(m_data);
      #1;
      got = bus.readData1; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL rand_rd1[%0d] got %h want %h", c, got, exp_v); end
      got = bus.readData2; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL rand_rd2[%0d] got %h want %h", c, got, exp_v); end
      got = bus.wbData; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL rand_wbdata[%0d] got %h want %h", c, got, exp_v); end
      got = {16'h0, bus.wrCount}; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL rand_wrcount[%0d] got %h want %h", c, got, exp_v); end
      got = {27'h0, bus.lastWrAddr}; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL rand_lastaddr[%0d] got %h want %h", c, got, exp_v); end
      got = bus.lastWrData; exp_v = exp_q.pop_front(); n_vec++;
      if (got !== exp_v) begin n_err++; $display("FAIL rand_lastdata[%0d] got %h want %h", c, got, exp_v); end
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_alu_write();
    test_mem_bypass();
    test_zero_write();
    test_no_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back consumer of the MEM/WB pipeline register.
- Takes the latched memory read data, ALU result, destination register number and the regWrite/memToReg controls, and selects the write-back value.
- Commits that value into the 32-entry general-purpose register file.
- Serves two combinational read ports to the decode stage, with write-to-read bypass so the decode stage sees a same-cycle write without a separate hazard stall.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width.
- NREGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- readData  input  DATA_W  data-memory word from the MEM/WB register.
- aluResult  input  DATA_W  ALU result from the MEM/WB register.
- muxRegFileData  input  ADDR_W  destination register index from the MEM/WB register.
- regWrite  input  1  write enable from the MEM/WB register.
- memToReg  input  1  1 selects readData, 0 selects aluResult.
- readReg1  input  ADDR_W  read port 1 index (rs).
- readReg2  input  ADDR_W  read port 2 index (rt).
- readData1  output  DATA_W  read port 1 value.
- readData2  output  DATA_W  read port 2 value.
- wbData  output  DATA_W  selected write-back value (combinational, for forwarding units).
- lastWrAddr  output  ADDR_W  index of the most recent committed write (registered).
- lastWrData  output  DATA_W  value of the most recent committed write (registered).
- wrCount  output  16  number of committed writes, wraps at 0xFFFF -> 0.

Behaviour:
- Reset is asynchronous and active-high.
  - While reset=1, all NREGS entries, lastWrAddr, lastWrData and wrCount are forced to 0 immediately, independent of clk.
  - Consequently readData1/readData2 read 0 during reset.
  - Deassertion takes effect at the next rising edge.
- Write-back mux (combinational): wbData = memToReg ? readData : aluResult.
- Commit condition: wrEn = regWrite && (muxRegFileData != 0).
- On a rising clk edge with wrEn=1:
  - regs[muxRegFileData] <= wbData;
  - lastWrAddr <= muxRegFileData;
  - lastWrData <= wbData;
  - wrCount <= wrCount + 1 (mod 2^16).
- Register 0 is hardwired to 0.
  - Writes to index 0 are discarded.
  - A discarded write does not update lastWrAddr, lastWrData or wrCount.
- With regWrite=0, no state changes regardless of memToReg or data inputs.
- Read ports are combinational, zero latency.
  - readDataN = 0 if readRegN == 0.
  - Otherwise readDataN = wbData if wrEn && readRegN == muxRegFileData (bypass of the write committing at the next edge).
  - Otherwise readDataN = regs[readRegN].
- Both ports may address the same register, and both may hit the bypass simultaneously. Each resolves independently with identical values.
- Back-to-back writes to the same index: the last edge wins, and no intermediate value is lost to the bypass ordering.
- Reset asserted mid-operation: any write pending at that edge is lost. The register file is all-zero after reset regardless of in-flight MEM/WB contents.
- X on memToReg while regWrite=0 must not corrupt state.

Decomposition:
- Shared package (pipeline defs):
  - DATA_W, ADDR_W, NREGS
  - REG_ZERO = 0
  - WB_SEL_ALU = 0, WB_SEL_MEM = 1 constants for memToReg encoding.
- One natural sub-module: wb_mux (2:1 DATA_W write-back selector), shared with the forwarding unit.
- Register array, bypass logic and trace counters stay in wb_regfile.

Test Plan:
- Reset with random inputs driving, then read all 32 indices -> all readData = 0; wrCount=0; lastWrAddr=0.
- regWrite=1, memToReg=0, aluResult=0x0000_1234, dest=5, edge; then readReg1=5 -> readData1=0x0000_1234, lastWrAddr=5, wrCount=1.
- regWrite=1, memToReg=1, readData=0xDEAD_BEEF, aluResult=0x1, dest=7, readReg2=7 in the same cycle before the edge -> readData2=0xDEAD_BEEF via bypass; after the edge, still 0xDEAD_BEEF from the array.
- regWrite=1, dest=0, aluResult=0xFFFF_FFFF -> readData1(readReg1=0)=0 both before and after the edge; wrCount unchanged.
- regWrite=0, memToReg toggling, dest=3, data 0xAAAA_AAAA -> reg3 keeps its prior value 0x0000_0000; lastWrData unchanged.
- Write 0x55 to reg9, then assert reset asynchronously mid-cycle with regWrite=1 dest=9 data=0x66 -> reg9 reads 0 immediately; wrCount=0; after release, no write of 0x66 has occurred.
